// File: rtl/mnist_batch_sequencer.sv
// mnist_batch_sequencer: walks every stored image through the systolic
// fetcher / arg-max datapath, decodes the one-hot class, scores it against
// the label source and logs one result per image.
// Optional feature: define SEQ_WATCHDOG_EN to build the wait-state watchdog.
module mnist_batch_sequencer #(
    parameter int unsigned IMAGES         = 10,
    parameter int unsigned CLASSES        = 10,
    parameter int unsigned IDX_W          = 4,
    parameter int unsigned CNT_W          = 8,
    parameter int unsigned TIMEOUT_CYCLES = 4096
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic               abort,
    output logic [IDX_W-1:0]   image_num,
    output logic               arr_load,
    output logic               arr_start,
    input  logic               arr_ready,
    input  logic [CLASSES-1:0] arr_classes,
    input  logic [IDX_W-1:0]   label,
    output logic               busy,
    output logic               done,
    output logic               result_we,
    output logic [IDX_W-1:0]   result_addr,
    output logic [IDX_W-1:0]   result_class,
    output logic               result_hit,
    output logic [CNT_W-1:0]   correct_cnt,
    output logic               error
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_START,
        S_WAIT_LOW,
        S_WAIT_HIGH,
        S_CAPTURE,
        S_DONE
    } state_t;

    state_t             state_q, state_d;
    logic [IDX_W-1:0]   img_q, img_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               err_q, err_d;
    logic               rdy_q;
    logic               timed_out;

    logic [IDX_W-1:0]   dec_idx;
    logic [1:0]         dec_cnt;
    logic [IDX_W-1:0]   cap_class;
    logic               cap_invalid;
    logic               cap_hit;

`ifdef SEQ_WATCHDOG_EN
    localparam int unsigned WD_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [WD_W-1:0]    wd_q, wd_d;
    logic               to_q, to_d;
    assign timed_out = to_q;
`else
    assign timed_out = 1'b0;
`endif

    // One-hot decode: index of the last set bit plus a saturating set-bit count
    always_comb begin
        dec_idx = '0;
        dec_cnt = '0;
        for (int unsigned i = 0; i < CLASSES; i++) begin
            if (arr_classes[i]) begin
                dec_idx = i[IDX_W-1:0];
                if (dec_cnt != 2'd2) begin
                    dec_cnt = dec_cnt + 2'd1;
                end
            end
        end
    end

    assign cap_invalid = (dec_cnt != 2'd1) || timed_out;
    assign cap_class   = cap_invalid ? '1 : dec_idx;
    assign cap_hit     = !cap_invalid && (cap_class == label);

    // Next-state, counter updates and strobe decode; abort overrides last
    always_comb begin
        state_d      = state_q;
        img_d        = img_q;
        cnt_d        = cnt_q;
        err_d        = err_q;
        arr_load     = 1'b0;
        arr_start    = 1'b0;
        done         = 1'b0;
        result_we    = 1'b0;
        result_addr  = '0;
        result_class = '0;
        result_hit   = 1'b0;
`ifdef SEQ_WATCHDOG_EN
        wd_d         = '0;
        to_d         = to_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (start && !abort) begin
                    state_d = S_LOAD;
                    img_d   = '0;
                    cnt_d   = '0;
                    err_d   = 1'b0;
                end
            end
            S_LOAD: begin
                arr_load = 1'b1;
                state_d  = S_START;
            end
            S_START: begin
                arr_start = 1'b1;
                state_d   = S_WAIT_LOW;
`ifdef SEQ_WATCHDOG_EN
                to_d      = 1'b0;
`endif
            end
            S_WAIT_LOW: begin
                if (!rdy_q) begin
                    state_d = S_WAIT_HIGH;
                end
            end
            S_WAIT_HIGH: begin
                if (rdy_q) begin
                    state_d = S_CAPTURE;
                end
            end
            S_CAPTURE: begin
                result_we    = 1'b1;
                result_addr  = img_q;
                result_class = cap_class;
                result_hit   = cap_hit;
                if (cap_hit) begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
                if (cap_invalid) begin
                    err_d = 1'b1;
                end
                if (img_q == IDX_W'(IMAGES - 1)) begin
                    state_d = S_DONE;
                end else begin
                    img_d   = img_q + IDX_W'(1);
                    state_d = S_LOAD;
                end
            end
            S_DONE: begin
                done    = 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

`ifdef SEQ_WATCHDOG_EN
        // Wait cycles are counted across both wait states; a normal capture wins a tie
        if (state_q == S_WAIT_LOW || state_q == S_WAIT_HIGH) begin
            wd_d = wd_q + WD_W'(1);
            if (state_d != S_CAPTURE && wd_q == WD_W'(TIMEOUT_CYCLES - 1)) begin
                state_d = S_CAPTURE;
                to_d    = 1'b1;
            end
        end
`endif

        if (abort && state_q != S_IDLE) begin
            state_d      = S_IDLE;
            img_d        = img_q;
            cnt_d        = cnt_q;
            err_d        = err_q;
            arr_load     = 1'b0;
            arr_start    = 1'b0;
            done         = 1'b0;
            result_we    = 1'b0;
            result_addr  = '0;
            result_class = '0;
            result_hit   = 1'b0;
        end
    end

    // State, counters and the ready synchroniser register
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            img_q   <= '0;
            cnt_q   <= '0;
            err_q   <= 1'b0;
            rdy_q   <= 1'b0;
`ifdef SEQ_WATCHDOG_EN
            wd_q    <= '0;
            to_q    <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            img_q   <= img_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
            rdy_q   <= arr_ready;
`ifdef SEQ_WATCHDOG_EN
            wd_q    <= wd_d;
            to_q    <= to_d;
`endif
        end
    end

    assign image_num   = img_q;
    assign correct_cnt = cnt_q;
    assign error       = err_q;
    assign busy        = (state_q != S_IDLE);

endmodule

// File: tb/tb_mnist_batch_sequencer.sv
// Directed bench for mnist_batch_sequencer: the bench plays the datapath
// (ready/one-hot result) and the label ROM, and checks every logged result.
module tb_mnist_batch_sequencer;

    logic       clk = 1'b0;
    logic       reset, start, abort, arr_ready;
    logic [9:0] arr_classes;
    logic [3:0] label, image_num, result_addr, result_class;
    logic       arr_load, arr_start, busy, done, result_we, result_hit, error;
    logic [7:0] correct_cnt;

    logic [3:0] labels [10] = '{4'd3, 4'd1, 4'd4, 4'd1, 4'd5, 4'd9, 4'd2, 4'd6, 4'd5, 4'd3};

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    assign label = (image_num < 4'd10) ? labels[image_num] : 4'd0;

    mnist_batch_sequencer #(
        .IMAGES(10),
        .CLASSES(10),
        .IDX_W(4),
        .CNT_W(8),
        .TIMEOUT_CYCLES(16)
    ) dut (
        .clk(clk),
        .reset(reset),
        .start(start),
        .abort(abort),
        .image_num(image_num),
        .arr_load(arr_load),
        .arr_start(arr_start),
        .arr_ready(arr_ready),
        .arr_classes(arr_classes),
        .label(label),
        .busy(busy),
        .done(done),
        .result_we(result_we),
        .result_addr(result_addr),
        .result_class(result_class),
        .result_hit(result_hit),
        .correct_cnt(correct_cnt),
        .error(error)
    );

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation did not finish, required finish before time limit");
        $fatal(1, "timeout");
    end

    function automatic logic [9:0] onehot(input int c);
        logic [9:0] v;
        v = 10'd1;
        return v << c;
    endfunction

    task automatic do_start();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    // Serve one image: check load/start strobes, optionally hold a stale ready,
    // then deliver cls and check the logged result and the updated count.
    task automatic serve(input int addr, input logic [9:0] cls, input int stale, input logic poke,
                         input logic [3:0] exp_cls, input logic exp_hit, input int exp_cnt);
        int cyc;
        cyc = 0;
        while (arr_load !== 1'b1 && cyc < 60) begin
            @(negedge clk);
            cyc++;
        end
        n_checks++;
        if (arr_load !== 1'b1 || image_num !== 4'(addr)) begin
            n_fail++;
            $display("FAIL load_%0d: arr_load=%b image_num=%0d, required 1 and %0d", addr, arr_load, image_num, addr);
        end
        @(negedge clk);
        n_checks++;
        if (arr_start !== 1'b1 || arr_load !== 1'b0) begin
            n_fail++;
            $display("FAIL start_strobe_%0d: arr_start=%b arr_load=%b, required 1 and 0", addr, arr_start, arr_load);
        end
        for (int k = 0; k < stale; k++) begin
            @(negedge clk);
            n_checks++;
            if (result_we !== 1'b0) begin
                n_fail++;
                $display("FAIL stale_capture_%0d: result_we=%b, required 0", addr, result_we);
            end
        end
        arr_ready = 1'b0;
        if (poke) start = 1'b1;
        repeat (2) @(negedge clk);
        start       = 1'b0;
        arr_classes = cls;
        arr_ready   = 1'b1;
        cyc = 0;
        while (result_we !== 1'b1 && cyc < 60) begin
            @(negedge clk);
            cyc++;
        end
        n_checks++;
        if (cyc != 2 || result_addr !== 4'(addr) || result_class !== exp_cls || result_hit !== exp_hit) begin
            n_fail++;
            $display("FAIL capture_%0d: latency=%0d addr=%0d class=%h hit=%b, required 2 %0d %h %b",
                     addr, cyc, result_addr, result_class, result_hit, addr, exp_cls, exp_hit);
        end
        @(negedge clk);
        n_checks++;
        if (correct_cnt !== 8'(exp_cnt) || result_we !== 1'b0) begin
            n_fail++;
            $display("FAIL count_%0d: correct_cnt=%0d result_we=%b, required %0d and 0", addr, correct_cnt, result_we, exp_cnt);
        end
    endtask

    // Run into WAIT_HIGH of image addr without ever delivering a result
    task automatic enter_wait_high(input int addr);
        int cyc;
        cyc = 0;
        while (arr_load !== 1'b1 && cyc < 60) begin
            @(negedge clk);
            cyc++;
        end
        n_checks++;
        if (image_num !== 4'(addr)) begin
            n_fail++;
            $display("FAIL partial_load_%0d: image_num=%0d, required %0d", addr, image_num, addr);
        end
        @(negedge clk);
        arr_ready = 1'b0;
        repeat (3) @(negedge clk);
    endtask

    task automatic test_reset();
        reset = 1'b1; start = 1'b0; abort = 1'b0; arr_ready = 1'b0; arr_classes = '0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        n_checks++;
        if ({busy, done, arr_load, arr_start, result_we, result_hit, error, image_num,
             result_addr, result_class, correct_cnt} !== '0) begin
            n_fail++;
            $display("FAIL reset_state: busy=%b done=%b img=%0d cnt=%0d err=%b, required all zero",
                     busy, done, image_num, correct_cnt, error);
        end
    endtask

    task automatic test_start_abort();
        @(negedge clk);
        start = 1'b1; abort = 1'b1;
        @(negedge clk);
        start = 1'b0; abort = 1'b0;
        n_checks++;
        if (busy !== 1'b0 || arr_load !== 1'b0) begin
            n_fail++;
            $display("FAIL start_abort_idle: busy=%b arr_load=%b, required 0 and 0", busy, arr_load);
        end
        @(negedge clk);
        n_checks++;
        if (busy !== 1'b0) begin
            n_fail++;
            $display("FAIL start_abort_hold: busy=%b, required 0", busy);
        end
    endtask

    task automatic test_full_batch();
        int cnt, c, l;
        logic hit;
        cnt = 0;
        do_start();
        n_checks++;
        if (arr_load !== 1'b1 || busy !== 1'b1) begin
            n_fail++;
            $display("FAIL load_latency: arr_load=%b busy=%b, required 1 and 1", arr_load, busy);
        end
        for (int i = 0; i < 10; i++) begin
            l   = int'(labels[i]);
            hit = !(i == 2 || i == 5 || i == 8);
            c   = hit ? l : (l + 1) % 10;
            if (hit) cnt++;
            serve(i, onehot(c), 0, 1'b0, 4'(c), hit, cnt);
        end
        n_checks++;
        if (done !== 1'b1 || correct_cnt !== 8'd7 || error !== 1'b0 || busy !== 1'b1) begin
            n_fail++;
            $display("FAIL batch_done: done=%b cnt=%0d err=%b busy=%b, required 1 7 0 1", done, correct_cnt, error, busy);
        end
        @(negedge clk);
        n_checks++;
        if (done !== 1'b0 || busy !== 1'b0 || correct_cnt !== 8'd7 || image_num !== 4'd9) begin
            n_fail++;
            $display("FAIL batch_idle: done=%b busy=%b cnt=%0d img=%0d, required 0 0 7 9", done, busy, correct_cnt, image_num);
        end
    endtask

    task automatic test_invalid_onehot();
        int cnt;
        cnt = 0;
        do_start();
        for (int i = 0; i < 10; i++) begin
            if (i == 4) begin
                serve(i, 10'b0000000011, 0, 1'b0, 4'hF, 1'b0, cnt);
                n_checks++;
                if (error !== 1'b1) begin
                    n_fail++;
                    $display("FAIL invalid_error: error=%b, required 1", error);
                end
            end else begin
                cnt++;
                serve(i, onehot(int'(labels[i])), 0, (i == 6), labels[i], 1'b1, cnt);
            end
        end
        n_checks++;
        if (done !== 1'b1 || correct_cnt !== 8'd9 || error !== 1'b1) begin
            n_fail++;
            $display("FAIL invalid_done: done=%b cnt=%0d err=%b, required 1 9 1", done, correct_cnt, error);
        end
        @(negedge clk);
    endtask

    task automatic test_stale_ready();
        int cnt;
        cnt = 0;
        do_start();
        n_checks++;
        if (error !== 1'b0 || correct_cnt !== 8'd0) begin
            n_fail++;
            $display("FAIL start_clears: error=%b cnt=%0d, required 0 and 0", error, correct_cnt);
        end
        for (int i = 0; i < 10; i++) begin
            cnt++;
            serve(i, onehot(int'(labels[i])), 3, 1'b0, labels[i], 1'b1, cnt);
        end
        n_checks++;
        if (done !== 1'b1 || correct_cnt !== 8'd10 || error !== 1'b0) begin
            n_fail++;
            $display("FAIL stale_done: done=%b cnt=%0d err=%b, required 1 10 0", done, correct_cnt, error);
        end
        @(negedge clk);
    endtask

    task automatic test_abort();
        int bad;
        do_start();
        for (int i = 0; i < 3; i++) serve(i, onehot(int'(labels[i])), 0, 1'b0, labels[i], 1'b1, i + 1);
        enter_wait_high(3);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        n_checks++;
        if (busy !== 1'b0 || result_we !== 1'b0 || done !== 1'b0 || correct_cnt !== 8'd3 || image_num !== 4'd3) begin
            n_fail++;
            $display("FAIL abort_idle: busy=%b we=%b done=%b cnt=%0d img=%0d, required 0 0 0 3 3",
                     busy, result_we, done, correct_cnt, image_num);
        end
        arr_classes = onehot(int'(labels[3]));
        arr_ready   = 1'b1;
        bad = 0;
        repeat (6) begin
            @(negedge clk);
            if (done !== 1'b0 || result_we !== 1'b0 || busy !== 1'b0) bad++;
        end
        n_checks++;
        if (bad != 0) begin
            n_fail++;
            $display("FAIL abort_quiet: %0d cycles with activity, required 0", bad);
        end
    endtask

    task automatic test_reset_mid();
        do_start();
        for (int i = 0; i < 3; i++) serve(i, onehot(int'(labels[i])), 0, 1'b0, labels[i], 1'b1, i + 1);
        enter_wait_high(3);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        n_checks++;
        if ({busy, done, arr_load, arr_start, result_we, result_hit, error, image_num,
             result_addr, result_class, correct_cnt} !== '0) begin
            n_fail++;
            $display("FAIL reset_mid: busy=%b img=%0d cnt=%0d err=%b, required all zero", busy, image_num, correct_cnt, error);
        end
    endtask

`ifdef SEQ_WATCHDOG_EN
    task automatic test_watchdog();
        int cyc;
        do_start();
        for (int i = 0; i < 2; i++) serve(i, onehot(int'(labels[i])), 0, 1'b0, labels[i], 1'b1, i + 1);
        while (arr_load !== 1'b1 && cyc < 60) begin
            @(negedge clk);
            cyc++;
        end
        @(negedge clk);
        arr_ready = 1'b0;
        cyc = 0;
        while (result_we !== 1'b1 && cyc < 100) begin
            @(negedge clk);
            cyc++;
        end
        n_checks++;
        if (cyc != 17 || result_addr !== 4'd2 || result_class !== 4'hF || result_hit !== 1'b0) begin
            n_fail++;
            $display("FAIL wd_capture: after=%0d addr=%0d class=%h hit=%b, required 17 2 f 0",
                     cyc, result_addr, result_class, result_hit);
        end
        @(negedge clk);
        n_checks++;
        if (error !== 1'b1 || arr_load !== 1'b1 || image_num !== 4'd3) begin
            n_fail++;
            $display("FAIL wd_next: err=%b load=%b img=%0d, required 1 1 3", error, arr_load, image_num);
        end
        for (int i = 3; i < 10; i++) serve(i, onehot(int'(labels[i])), 0, 1'b0, labels[i], 1'b1, i);
        n_checks++;
        if (done !== 1'b1 || correct_cnt !== 8'd9 || error !== 1'b1) begin
            n_fail++;
            $display("FAIL wd_done: done=%b cnt=%0d err=%b, required 1 9 1", done, correct_cnt, error);
        end
        @(negedge clk);
    endtask
`endif

    initial begin
        test_reset();
        test_start_abort();
        test_full_batch();
        test_invalid_onehot();
        test_stale_ready();
        test_abort();
        test_reset_mid();
`ifdef SEQ_WATCHDOG_EN
        test_watchdog();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/mnist_batch_sequencer.md
# mnist_batch_sequencer

Batch controller for the MNIST inference datapath: systolic-array fetcher, bias add, max_num arg-max and 7-segment output. It steps through every stored image in turn and drives the image index plus the load and compute strobes. For each image it waits for the arg-max result, decodes the one-hot class, and compares it against a label source. It logs each result and keeps a running correct-prediction count, so a whole test set classifies with one `start` pulse.

## Interface
Parameters:
- `IMAGES`, 10 — images in the batch; image indices are 0..IMAGES-1.
- `CLASSES`, 10 — width of the one-hot class vector.
- `IDX_W`, 4 — width of image index and class index; must satisfy 2^IDX_W > max(IMAGES, CLASSES).
- `CNT_W`, 8 — width of the correct-prediction counter; must satisfy 2^CNT_W > IMAGES.
- `TIMEOUT_CYCLES`, 4096 — watchdog limit; used only with the watchdog configuration.

Ports:
- `clk` input 1 — single clock; all logic on the rising edge.
- `reset` input 1 — synchronous, active-high.
- `start` input 1 — begin a batch; sampled only in IDLE.
- `abort` input 1 — cancel the batch in progress.
- `image_num` output IDX_W — index of the current image, to the image ROM mux and the label ROM.
- `arr_load` output 1 — one-cycle, active-high parameter-load strobe to the fetcher.
- `arr_start` output 1 — one-cycle, active-high compute strobe to the fetcher.
- `arr_ready` input 1 — level signal from max_num; high while a result is valid.
- `arr_classes` input CLASSES — one-hot arg-max result.
- `label` input IDX_W — expected class for `image_num`; combinational, valid in the same cycle.
- `busy` output 1 — high in every state except IDLE.
- `done` output 1 — one-cycle pulse when a batch completes.
- `result_we` output 1 — one-cycle write strobe for the per-image result log.
- `result_addr` output IDX_W — image index being logged.
- `result_class` output IDX_W — decoded class; 4'hF means invalid.
- `result_hit` output 1 — `result_class` equals `label`.
- `correct_cnt` output CNT_W — running count of hits.
- `error` output 1 — sticky; set by an invalid one-hot vector or a watchdog expiry.

## Operation
- FSM states: IDLE, LOAD, START, WAIT_LOW, WAIT_HIGH, CAPTURE, DONE.
- IDLE:
  - `start` moves to LOAD and clears `image_num`, `correct_cnt` and `error`.
  - `start` while busy is ignored.
- LOAD: `arr_load`=1 for exactly one cycle, then START.
- START: `arr_start`=1 for exactly one cycle, then WAIT_LOW.
- WAIT_LOW: wait for `arr_ready`=0.
  - A stale high result from the previous image must never be captured.
  - When `arr_ready`=0, move to WAIT_HIGH.
- WAIT_HIGH: wait for `arr_ready`=1, then CAPTURE.
- CAPTURE, one cycle, class decode:
  - Exactly one bit k of `arr_classes` set: `result_class`=k.
  - Zero bits or more than one bit set: `result_class`=4'hF and `error` is set.
- CAPTURE, compare and log:
  - `result_hit` = (`result_class` == `label`); 4'hF never hits.
  - `result_we`=1 and `result_addr`=`image_num`.
  - `correct_cnt` increments on a hit; it cannot overflow because 2^CNT_W > IMAGES.
- CAPTURE, next state:
  - `image_num`==IMAGES-1: go to DONE.
  - Otherwise: increment `image_num` and go to LOAD.
- DONE: `done`=1 for one cycle, then IDLE.
  - `image_num`, `correct_cnt` and `error` hold their values until the next accepted `start`.
- `abort`:
  - In any state other than IDLE, returns the FSM to IDLE on the next edge.
  - No `done` and no `result_we` are issued.
  - Counters hold their values.
  - In IDLE, `abort` wins over a simultaneous `start`.
- `reset`:
  - Resets to IDLE on the next edge, mid-operation included.
  - Every output resets to 0.

## Timing
- `start` accepted on edge T: `arr_load`=1 in cycle T+1, `arr_start`=1 in cycle T+2.
- `arr_ready` is registered before use. The FSM reaches CAPTURE 2 cycles after `arr_ready` first goes high.
- `result_*` outputs are valid in the same cycle as `result_we`. `correct_cnt` shows the updated value one cycle later.
- Next image: `arr_load` comes 1 cycle after CAPTURE.
- Per-image overhead, excluding datapath latency: 5 cycles.
- `done` is asserted 1 cycle after the last CAPTURE.
- Strobes (`arr_load`, `arr_start`, `result_we`, `done`) are never high for two consecutive cycles.

## Configuration
- Macro: `SEQ_WATCHDOG_EN`.
- Defined:
  - A counter runs in WAIT_LOW and WAIT_HIGH.
  - If TIMEOUT_CYCLES cycles elapse in those states without advancing to CAPTURE, the FSM goes to CAPTURE anyway.
  - That capture logs `result_class`=4'hF, `result_hit`=0 and sets `error`; the batch then continues with the next image.
- Not defined:
  - No counter is built; the FSM waits indefinitely.
  - `TIMEOUT_CYCLES` is ignored.

## Test plan
- Full batch: IMAGES=10; model returns one-hot `arr_classes` = 1<<label for 7 images and a wrong class for 3 → 10 `result_we` pulses at addresses 0..9, `correct_cnt`=7, one `done` pulse, `error`=0.
- Stale ready: `arr_ready` held high from the previous image when START ends → no capture until `arr_ready` drops and rises again; `result_addr` increments by exactly 1 per capture.
- Invalid one-hot: `arr_classes`=10'b0000000011 on image 4 → `result_class`=4'hF, `result_hit`=0, `error`=1; remaining images still processed.
- Abort and reset: `abort` asserted during WAIT_HIGH of image 3 → IDLE next cycle, `done` never pulses, `correct_cnt` holds. Same stimulus with `reset` → all outputs 0 on the next edge.
- Simultaneous and redundant events: `start` and `abort` high together in IDLE → stays IDLE. `start` re-pulsed while busy → ignored; `image_num` sequence undisturbed.
- Watchdog (`SEQ_WATCHDOG_EN` defined, TIMEOUT_CYCLES=16): `arr_ready` never rises on image 2 → capture after 16 wait cycles with 4'hF, `error`=1, image 3 is loaded next.
